adc_responder: RTL and testbench
================================

ADC_RESPONDER -- requirements
Module: adc_responder

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 10, meaning the serial sample width in bits.
REQ-002 SHALL have parameter NULL_SLOTS, default 2, meaning the number of slots between the last channel bit and the sample MSB.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  single clock; all logic on rising edge; the initiator drives on falling edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 conv  in  1  frame select; 0 = frame active, 1 = end/abort frame.
REQ-007 ADC_in  in  1  serial command from the initiator (start, SGL/DIFF, channel MSB first).
REQ-008 ADC_out  out  1  serial sample to the initiator, MSB first.
REQ-009 sample_req  out  1  one-cycle request for a sample of sample_ch.
REQ-010 sample_ch  out  3  channel decoded from the command.
REQ-011 sample_ack  in  1  sample_data valid this cycle.
REQ-012 sample_data  in  SAMPLE_W  sample value, captured when sample_ack=1.
REQ-013 sgl_diff  out  1  captured SGL/DIFF bit of the current or last frame.
REQ-014 frame_done  out  1  one-cycle pulse when a full frame has been shifted out.
REQ-015 underrun  out  1  sticky; set when no ack arrived before the MSB slot.

Function
REQ-016 Rising edges are numbered r1..r18 within a frame, where r1 is the edge that accepts the start bit.
REQ-017 In IDLE, r1 SHALL occur at the first rising edge with conv=0 and ADC_in=1.
  - Edges with conv=0 and ADC_in=0 are ignored (leading zeros).
REQ-018 States SHALL be IDLE, CMD, WAIT, SHIFT, TAIL.
  - IDLE->CMD at r1.
  - CMD covers r2..r5.
  - WAIT covers r6..r(5+NULL_SLOTS).
  - SHIFT covers r8..r17.
  - SHIFT->TAIL at r18.
  - TAIL->IDLE when conv=1.
REQ-019 CMD SHALL capture sgl_diff at r2, and channel bits [2], [1], [0] at r3, r4, r5.
REQ-020 sample_ch SHALL update at r5; sample_req SHALL be high for exactly the cycle following r5.
REQ-021 During WAIT, sample_data SHALL be captured at the first edge with sample_ack=1.
  - sample_ack at r5 or earlier is ignored.
  - A later ack in the same frame is ignored.
REQ-022 If no ack is captured by r7, the shifted value SHALL be all zeros and underrun SHALL set at r8.
REQ-023 At r(8+j), j=0..9, ADC_out SHALL take captured bit [9-j], so bit [9-j] is valid at the initiator's falling edge ending that slot.
REQ-024 At r18, ADC_out SHALL go to 0 and frame_done SHALL pulse for one cycle.
REQ-025 ADC_out SHALL be 0 in IDLE, CMD, WAIT and TAIL.
REQ-026 conv=1 in CMD, WAIT or SHIFT (abort) SHALL force IDLE and ADC_out=0 at that edge.
  - No frame_done.
  - sample_req suppressed if not yet issued.
  - A pending ack is discarded.
REQ-027 conv=1 together with ADC_in=1 SHALL NOT start a frame; the start is accepted only with conv=0.
REQ-028 Back-to-back frames: a TAIL->IDLE edge followed immediately by conv=0, ADC_in=1 SHALL start the next frame on the next edge.
REQ-029 underrun SHALL clear at the next r1 and SHALL hold otherwise.
REQ-030 The slot counter SHALL be 5 bits, SHALL saturate in TAIL, and SHALL never wrap within a frame.

Reset
REQ-031 rst=1 SHALL force state IDLE and clear the counter.
  - Outputs: ADC_out=0, sample_req=0, sample_ch=0, sgl_diff=0, frame_done=0, underrun=0.
  - Shift register cleared.
REQ-032 rst SHALL have priority over conv, ADC_in and sample_ack, including mid-frame; no frame_done is emitted.

Structure
REQ-033 Package adc_pkg SHALL hold:
  - state encoding;
  - SAMPLE_W, CMD_BITS=4, NULL_SLOTS=2, FRAME_SLOTS=18;
  - the slot index constants for r5, r7, r8 and r18.
REQ-034 Sub-module adc_piso SHALL implement the SAMPLE_W-bit parallel-load, MSB-first shift register.
  - Inputs: load, shift, zero_fill.

Verification
REQ-035 Frame with command 1,1,1,0,1, ack at r6, data 10'h2A5 -> sample_ch=5, sgl_diff=1; ADC_out over r8..r17 = 1010100101; frame_done at r18.
REQ-036 Command 1,0,0,1,1 with no ack -> sample_ch=3, sgl_diff=0; ADC_out all 0; underrun=1 from r8; underrun cleared at next r1.
REQ-037 Two leading zero slots, then start; ack at r7 with 10'h3FF -> frame shifted 2 cycles later, all ones; ack at r6 absent and ack at r8 ignored.
REQ-038 conv=1 at r12 -> IDLE, ADC_out=0, no frame_done; the next frame with data 10'h001 shifts correctly.
REQ-039 rst at r10 -> all outputs at reset values on the next cycle; a new start is accepted immediately after rst deasserts.
REQ-040 Back-to-back frames with one-cycle conv=1 gaps, channels 0..7 -> eight sample_req pulses, eight frame_done pulses, matching data.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC responder: FSM state encoding, default
// frame geometry and the slot numbers (rising-edge index inside a frame,
// r1 = start bit) that the control logic keys on.
package adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WAIT,
    ST_SHIFT,
    ST_TAIL
  } state_t;

  localparam int SAMPLE_W    = 10;
  localparam int CMD_BITS    = 4;   // SGL/DIFF + three channel bits
  localparam int NULL_SLOTS  = 2;
  localparam int FRAME_SLOTS = 18;

  // Slot numbers for the default geometry.
  localparam logic [4:0] SLOT_R5  = 5'd5;   // last command bit
  localparam logic [4:0] SLOT_R7  = 5'd7;   // last null slot
  localparam logic [4:0] SLOT_R8  = 5'd8;   // sample MSB
  localparam logic [4:0] SLOT_R18 = 5'd18;  // end of frame

endpackage

// File: rtl/adc_piso.sv
// Parallel-load, MSB-first shift register holding the sample being sent.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (clears contents)
//   load       - capture din
//   shift      - move contents one place toward the MSB, zero into LSB
//   zero_fill  - clear contents (highest priority after rst)
//   din        - parallel sample
//   msb        - current MSB
module adc_piso #(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic              zero_fill,
  input  logic [DATA_W-1:0] din,
  output logic              msb
);

  logic [DATA_W-1:0] sreg_p0;

  always_ff @(posedge clk) begin
    if (rst || zero_fill) begin
      sreg_p0 <= '0;
    end else if (load) begin
      sreg_p0 <= din;
    end else if (shift) begin
      sreg_p0 <= {sreg_p0[DATA_W-2:0], 1'b0};
    end
  end

  assign msb = sreg_p0[DATA_W-1];

endmodule

// File: rtl/adc_responder.sv
// Serial ADC responder. Accepts a start bit, SGL/DIFF and a 3-bit channel
// from the initiator, requests a sample from the local sample source, and
// returns it MSB first after NULL_SLOTS idle slots.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   conv           - 0 = frame active, 1 = end/abort frame
//   ADC_in         - serial command from the initiator
//   ADC_out        - serial sample to the initiator, MSB first
//   sample_req     - one-cycle request for channel sample_ch
//   sample_ch      - channel decoded from the command
//   sample_ack     - sample_data valid this cycle
//   sample_data    - sample value
//   sgl_diff       - SGL/DIFF bit of the current or last frame
//   frame_done     - pulse when the full sample has been shifted out
//   underrun       - sticky: no sample arrived before the MSB slot
module adc_responder
  import adc_pkg::*;
#(
  parameter int SAMPLE_W   = adc_pkg::SAMPLE_W,
  parameter int NULL_SLOTS = adc_pkg::NULL_SLOTS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                conv,
  input  logic                ADC_in,
  output logic                ADC_out,
  output logic                sample_req,
  output logic [2:0]          sample_ch,
  input  logic                sample_ack,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic                sgl_diff,
  output logic                frame_done,
  output logic                underrun
);

  // Slot numbers derived from the frame geometry.
  localparam int LAST_CMD_I    = 1 + CMD_BITS;
  localparam int LAST_WAIT_I   = LAST_CMD_I + NULL_SLOTS;
  localparam int FIRST_SHIFT_I = LAST_WAIT_I + 1;
  localparam int END_I         = FIRST_SHIFT_I + SAMPLE_W;

  localparam logic [4:0] SLOT_SGL         = 5'd2;
  localparam logic [4:0] SLOT_LAST_CMD    = 5'(LAST_CMD_I);
  localparam logic [4:0] SLOT_LAST_WAIT   = 5'(LAST_WAIT_I);
  localparam logic [4:0] SLOT_FIRST_SHIFT = 5'(FIRST_SHIFT_I);
  localparam logic [4:0] SLOT_END         = 5'(END_I);

  state_t     state, state_n;
  logic [4:0] cnt, cnt_n;      // number of frame edges already taken
  logic [4:0] slot;            // number of the edge being taken now
  logic [1:0] ch_hi, ch_hi_n;  // channel bits [2:1] while the command arrives
  logic       captured, captured_n;
  logic       adc_n, req_n, done_n, sgl_n, und_n;
  logic [2:0] ch_n;
  logic       load, shift, zero_fill, piso_msb;

  assign slot = cnt + 5'd1;

  adc_piso #(.DATA_W(SAMPLE_W)) u_piso (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .shift     (shift),
    .zero_fill (zero_fill),
    .din       (sample_data),
    .msb       (piso_msb)
  );

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ch_hi_n    = ch_hi;
    captured_n = captured;
    adc_n      = 1'b0;
    req_n      = 1'b0;
    done_n     = 1'b0;
    ch_n       = sample_ch;
    sgl_n      = sgl_diff;
    und_n      = underrun;
    load       = 1'b0;
    shift      = 1'b0;
    zero_fill  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (!conv && ADC_in) begin
          // r1: start bit. A fresh frame starts from a zero sample so a
          // missing ack shifts out zeros.
          state_n    = ST_CMD;
          cnt_n      = 5'd1;
          und_n      = 1'b0;
          captured_n = 1'b0;
          zero_fill  = 1'b1;
        end
      end

      ST_CMD, ST_WAIT, ST_SHIFT: begin
        if (conv) begin
          // Abort: nothing further of this frame is emitted.
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = slot;
          if (state == ST_CMD) begin
            if (slot == SLOT_SGL) begin
              sgl_n = ADC_in;
            end else begin
              ch_hi_n = {ch_hi[0], ADC_in};
            end
            if (slot == SLOT_LAST_CMD) begin
              ch_n    = {ch_hi, ADC_in};
              req_n   = 1'b1;
              state_n = ST_WAIT;
            end
          end else if (state == ST_WAIT) begin
            // Only the first ack of the frame is taken.
            if (sample_ack && !captured) begin
              load       = 1'b1;
              captured_n = 1'b1;
            end
            if (slot == SLOT_LAST_WAIT) begin
              state_n = ST_SHIFT;
            end
          end else begin
            if (slot == SLOT_END) begin
              state_n = ST_TAIL;
              done_n  = 1'b1;
            end else begin
              adc_n = piso_msb;
              shift = 1'b1;
              if (slot == SLOT_FIRST_SHIFT && !captured) begin
                und_n = 1'b1;
              end
            end
          end
        end
      end

      ST_TAIL: begin
        // Counter holds at the end slot until the initiator ends the frame.
        if (conv) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      end

      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ch_hi      <= '0;
      captured   <= 1'b0;
      ADC_out    <= 1'b0;
      sample_req <= 1'b0;
      sample_ch  <= '0;
      sgl_diff   <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ch_hi      <= ch_hi_n;
      captured   <= captured_n;
      ADC_out    <= adc_n;
      sample_req <= req_n;
      sample_ch  <= ch_n;
      sgl_diff   <= sgl_n;
      frame_done <= done_n;
      underrun   <= und_n;
    end
  end

endmodule

// File: tb/tb_adc_responder.sv
module tb_adc_responder;

  logic       clk = 1'b0;
  logic       rst, conv, ADC_in, sample_ack;
  logic [9:0] sample_data;
  logic       ADC_out, sample_req, sgl_diff, frame_done, underrun;
  logic [2:0] sample_ch;

  always #5 clk = ~clk;

  adc_responder #(.SAMPLE_W(10), .NULL_SLOTS(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .conv        (conv),
    .ADC_in      (ADC_in),
    .ADC_out     (ADC_out),
    .sample_req  (sample_req),
    .sample_ch   (sample_ch),
    .sample_ack  (sample_ack),
    .sample_data (sample_data),
    .sgl_diff    (sgl_diff),
    .frame_done  (frame_done),
    .underrun    (underrun)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: frame position as a plain edge number
  // (0 = idle, 1..17 = edges taken, 18 = tail).
  int         m_pos = 0;
  logic       m_adc = 0, m_req = 0, m_sgl = 0, m_done = 0, m_und = 0, m_cap = 0;
  logic [2:0] m_ch = 0, m_cmd = 0;
  logic [9:0] m_data = 0;

  int         req_cnt, done_cnt;
  logic [9:0] frame_bits;
  logic       und_r8, done_seen;

  typedef struct {
    logic       r, c, a, k;
    logic [9:0] d;
    logic [7:0] exp;  // {ADC_out, sample_req, sample_ch, sgl_diff, frame_done, underrun}
  } vec_t;
  vec_t tbl[$];

  function automatic logic [7:0] dut_vec();
    return {ADC_out, sample_req, sample_ch, sgl_diff, frame_done, underrun};
  endfunction

  function automatic logic [7:0] model_vec();
    return {m_adc, m_req, m_ch, m_sgl, m_done, m_und};
  endfunction

  task automatic model_step(input logic r, c, a, k, input logic [9:0] d);
    int n;
    m_req = 0; m_done = 0; m_adc = 0;
    if (r) begin
      m_pos = 0; m_ch = 0; m_sgl = 0; m_und = 0; m_cap = 0; m_data = 0;
    end else if (m_pos == 0) begin
      if (!c && a) begin
        m_pos = 1; m_und = 0; m_cap = 0; m_data = 0;
      end
    end else if (m_pos == 18) begin
      if (c) m_pos = 0;
    end else if (c) begin
      m_pos = 0;
    end else begin
      n = m_pos + 1;
      m_pos = n;
      if (n == 2) m_sgl = a;
      if (n >= 3 && n <= 5) m_cmd[5-n] = a;
      if (n == 5) begin m_ch = m_cmd; m_req = 1; end
      if ((n == 6 || n == 7) && k && !m_cap) begin m_cap = 1; m_data = d; end
      if (n >= 8 && n <= 17) m_adc = m_data[17-n];
      if (n == 8 && !m_cap) m_und = 1;
      if (n == 18) m_done = 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input logic r, c, a, k, input logic [9:0] d);
    @(negedge clk);
    rst = r; conv = c; ADC_in = a; sample_ack = k; sample_data = d;
    @(posedge clk);
    model_step(r, c, a, k, d);
    #1;
    if (sample_req) req_cnt++;
    if (frame_done) done_cnt++;
  endtask

  task automatic step(input logic r, c, a, k, input logic [9:0] d);
    tick(r, c, a, k, d);
    check("model", 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic tv(input logic r, c, a, k, input logic [9:0] d, input logic [7:0] e);
    vec_t v;
    v.r = r; v.c = c; v.a = a; v.k = k; v.d = d; v.exp = e;
    tbl.push_back(v);
  endtask

  // One frame from the initiator's side; slot arguments of 0 mean "never".
  task automatic run_frame(input int lead, input logic sgl, input logic [2:0] ch,
                           input int ack_slot, input logic [9:0] d,
                           input int abort_slot, input int rst_slot, input int extra_ack);
    logic a, k;
    logic [9:0] dd;
    frame_bits = '0; und_r8 = 0; done_seen = 0;
    for (int i = 0; i < lead; i++) step(0, 0, 0, 0, 10'($urandom));
    for (int n = 1; n <= 18; n++) begin
      if (n == 1) a = 1;
      else if (n == 2) a = sgl;
      else if (n <= 5) a = ch[5-n];
      else a = 1'($urandom);
      k  = (n == ack_slot) || (n == extra_ack);
      dd = (n == ack_slot) ? d : (k ? ~d : 10'($urandom));
      if (n == rst_slot) begin step(1, 0, a, k, dd); return; end
      if (n == abort_slot) begin step(0, 1, a, k, dd); return; end
      step(0, 0, a, k, dd);
      if (n >= 8 && n <= 17) frame_bits[17-n] = ADC_out;
      if (n == 8) und_r8 = underrun;
      if (frame_done) done_seen = 1;
    end
    step(0, 1, 0, 0, 10'd0);
  endtask

  initial begin
    logic [9:0] pat;
    logic [9:0] d;
    int ack_slot, extra, abort_slot, rst_slot, r;

    rst = 1; conv = 1; ADC_in = 0; sample_ack = 0; sample_data = 0;
    req_cnt = 0; done_cnt = 0;

    // Table: reset, then command 1,1,1,0,1 with ack at r6, data 2A5.
    pat = 10'h2A5;
    tv(1, 1, 0, 0, 10'h000, 8'h00);   // reset state
    tv(0, 0, 1, 0, 10'h000, 8'h00);   // r1
    tv(0, 0, 1, 0, 10'h000, 8'h04);   // r2 sgl_diff=1
    tv(0, 0, 1, 0, 10'h000, 8'h04);   // r3
    tv(0, 0, 0, 0, 10'h000, 8'h04);   // r4
    tv(0, 0, 1, 0, 10'h000, 8'h6C);   // r5 ch=5, req next cycle
    tv(0, 0, 0, 1, 10'h2A5, 8'h2C);   // r6 ack
    tv(0, 0, 0, 0, 10'h000, 8'h2C);   // r7
    for (int j = 0; j < 10; j++) tv(0, 0, 0, 0, 10'h000, pat[9-j] ? 8'hAC : 8'h2C);
    tv(0, 0, 0, 0, 10'h000, 8'h2E);   // r18 frame_done
    tv(0, 1, 0, 0, 10'h000, 8'h2C);   // tail -> idle
    foreach (tbl[i]) begin
      tick(tbl[i].r, tbl[i].c, tbl[i].a, tbl[i].k, tbl[i].d);
      check($sformatf("tbl[%0d]", i), 32'(dut_vec()), 32'(tbl[i].exp));
    end

    // conv=1 with ADC_in=1 must not start a frame.
    step(0, 1, 1, 0, 10'h000);
    step(0, 1, 1, 0, 10'h000);

    // No ack: zeros shifted, underrun from r8, cleared at the next r1.
    run_frame(0, 0, 3'd3, 0, 10'h3AB, 0, 0, 0);
    check("noack_bits", 32'(frame_bits), 32'h0);
    check("noack_und_r8", 32'(und_r8), 32'h1);
    check("noack_ch", 32'(sample_ch), 32'h3);
    check("noack_sgl", 32'(sgl_diff), 32'h0);
    check("noack_done", 32'(done_seen), 32'h1);
    step(0, 0, 1, 0, 10'h000);
    check("und_clear_r1", 32'(underrun), 32'h0);
    step(0, 1, 0, 0, 10'h000);  // abort in CMD

    // Two leading zeros, ack at r7 with 3FF, a later ack at r8 ignored.
    run_frame(2, 1, 3'd1, 7, 10'h3FF, 0, 0, 8);
    check("late_ack_bits", 32'(frame_bits), 32'h3FF);
    check("late_ack_und", 32'(underrun), 32'h0);

    // Ack at r5 is ignored (r5 is not a WAIT edge).
    run_frame(0, 0, 3'd4, 5, 10'h155, 0, 0, 0);
    check("early_ack_bits", 32'(frame_bits), 32'h0);
    check("early_ack_und", 32'(underrun), 32'h1);

    // Abort at r12, then a clean frame with 001.
    done_cnt = 0;
    run_frame(0, 1, 3'd2, 6, 10'h155, 12, 0, 0);
    check("abort_adc", 32'(ADC_out), 32'h0);
    check("abort_done", 32'(done_cnt), 32'h0);
    run_frame(0, 0, 3'd6, 6, 10'h001, 0, 0, 0);
    check("after_abort_bits", 32'(frame_bits), 32'h001);
    check("after_abort_done", 32'(done_cnt), 32'h1);

    // Reset at r10, then an immediate start.
    done_cnt = 0;
    run_frame(0, 1, 3'd7, 6, 10'h2F0, 0, 10, 0);
    check("rst_outputs", 32'(dut_vec()), 32'h0);
    run_frame(0, 1, 3'd5, 7, 10'h18C, 0, 0, 0);
    check("after_rst_bits", 32'(frame_bits), 32'h18C);
    check("after_rst_ch", 32'(sample_ch), 32'h5);
    check("rst_done_cnt", 32'(done_cnt), 32'h1);

    // Back-to-back frames over channels 0..7, one-cycle conv=1 gaps.
    req_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      d = 10'(10'h040 * c + 10'h013 + c);
      run_frame(0, c[0], 3'(c), 6 + (c % 2), d, 0, 0, 0);
      check($sformatf("b2b_bits[%0d]", c), 32'(frame_bits), 32'(d));
      check($sformatf("b2b_ch[%0d]", c), 32'(sample_ch), 32'(c));
    end
    check("b2b_req_cnt", 32'(req_cnt), 32'd8);
    check("b2b_done_cnt", 32'(done_cnt), 32'd8);

    // Random frames against the model.
    for (int f = 0; f < 80; f++) begin
      r          = $urandom_range(0, 8);
      ack_slot   = (r == 0) ? 0 : r + 2;
      extra      = ($urandom_range(0, 2) == 0) ? $urandom_range(6, 12) : 0;
      abort_slot = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 17) : 0;
      rst_slot   = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 18) : 0;
      run_frame($urandom_range(0, 3), 1'($urandom), 3'($urandom), ack_slot,
                10'($urandom), abort_slot, rst_slot, extra);
      if ($urandom_range(0, 3) == 0) step(0, 1, 1'($urandom), 0, 10'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
